// File: rtl/fix_acc_if.sv
// Handshake bundle for the fix_acc Q8.8 accumulator.
// The slave modport faces the accumulator; master faces the producer/consumer.
interface fix_acc_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out;
    logic             out_ovf;
    logic             busy;

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out, out_ovf, busy
    );

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out, out_ovf, busy
    );
endinterface

// File: rtl/fix_acc.sv
// Sums len signed Q8.8 terms into a 16+LEN_W bit accumulator.
// Define FIX_ACC_SAT_EN to saturate the 16-bit result; default wraps.
module fix_acc #(
    parameter int LEN_W = 8
) (
    input logic     clk,
    input logic     rst,
    fix_acc_if.slave bus
);
    localparam int AW = 16 + LEN_W;
    localparam logic signed [AW-1:0] POS_MAX = AW'(32767);
    localparam logic signed [AW-1:0] NEG_MIN = AW'(-32768);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                 state, state_nx;
    logic signed [AW-1:0]   acc, acc_nx;
    logic [LEN_W-1:0]       cnt, cnt_nx;
    logic                   pos_ovf, neg_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        acc_nx        = acc;
        cnt_nx        = cnt;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_nx = '0;
                    if (bus.len == '0) begin
                        state_nx = DONE;
                    end else begin
                        cnt_nx   = bus.len;
                        state_nx = ACC;
                    end
                end
            end
            ACC: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    acc_nx = acc + {{LEN_W{bus.in_data[15]}}, bus.in_data};
                    cnt_nx = cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1))
                        state_nx = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign pos_ovf     = acc > POS_MAX;
    assign neg_ovf     = acc < NEG_MIN;
    assign bus.busy    = state != IDLE;
    // Flag is only meaningful alongside out_valid, so keep it quiet elsewhere.
    assign bus.out_ovf = (state == DONE) && (pos_ovf || neg_ovf);

`ifdef FIX_ACC_SAT_EN
    always_comb begin
        bus.out = acc[15:0];
        if (pos_ovf)
            bus.out = 16'h7FFF;
        else if (neg_ovf)
            bus.out = 16'h8000;
    end
`else
    assign bus.out = acc[15:0];
`endif
endmodule

// File: tb/tb_fix_acc.sv
// Self-checking bench for fix_acc against an integer-sum reference.
// Honours FIX_ACC_SAT_EN the same way as the design build.
module tb_fix_acc;
    localparam int LEN_W = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fix_acc_if #(.LEN_W(LEN_W)) bus ();

    fix_acc #(.LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic ref_ovf(input longint s);
        return (s > 32767) || (s < -32768);
    endfunction

    function automatic logic [15:0] ref_out(input longint s);
`ifdef FIX_ACC_SAT_EN
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
`endif
        return 16'(s);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: start, feed terms with gaps, stall the result.
    task automatic do_run(input logic [15:0] t[$], input int gap,
                          input int stall, input bit poke, input string nm);
        longint      s = 0;
        logic [15:0] eo;
        logic        eovf;
        foreach (t[i]) s += longint'($signed(t[i]));
        eo   = ref_out(s);
        eovf = ref_ovf(s);
        bus.start = 1'b1;
        bus.len   = LEN_W'(t.size());
        step;
        bus.start = 1'b0;
        bus.len   = LEN_W'($urandom);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy after start: got %b want 1", nm, bus.busy);
        end
        for (int i = 0; i < t.size(); i++) begin
            for (int g = 0; g < gap; g++) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 16'($urandom);
                bus.start    = poke;
                step;
            end
            bus.start    = poke;
            bus.in_valid = 1'b1;
            bus.in_data  = t[i];
            checks++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s beat %0d: in_ready=%b out_valid=%b want 1/0",
                         nm, i, bus.in_ready, bus.out_valid);
            end
            step;
            bus.in_valid = 1'b0;
            bus.start    = 1'b0;
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s done latency: out_valid=%b in_ready=%b want 1/0",
                     nm, bus.out_valid, bus.in_ready);
        end
        for (int k = 0; k <= stall; k++) begin
            checks++;
            if (bus.out !== eo || bus.out_ovf !== eovf || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s result cyc %0d: out=%h ovf=%b vld=%b want %h %b 1",
                         nm, k, bus.out, bus.out_ovf, bus.out_valid, eo, eovf);
            end
            if (k < stall) step;
        end
        bus.out_ready = 1'b1;
        bus.start     = poke;
        bus.len       = 8'd3;
        step;
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s return idle: out_valid=%b busy=%b want 0/0",
                     nm, bus.out_valid, bus.busy);
        end
        step;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s stays idle: busy=%b want 0", nm, bus.busy);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
        bus.in_data = '0; bus.out_ready = 1'b0;
        repeat (2) step;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_ovf, bus.busy} !== 4'b0 ||
            bus.out !== 16'h0000) begin
            errors++;
            $display("FAIL reset outputs: rdy=%b vld=%b ovf=%b busy=%b out=%h want 0",
                     bus.in_ready, bus.out_valid, bus.out_ovf, bus.busy, bus.out);
        end
        rst = 1'b0;
        step;
    endtask

    task automatic test_basic;
        logic [15:0] q[$] = '{16'h0100, 16'h0180, 16'hFF00};
        do_run(q, 0, 0, 1'b0, "basic");
        checks++;
        if (ref_out(384) !== 16'h0180) begin
            errors++;
            $display("FAIL basic model: got %h want 0180", ref_out(384));
        end
    endtask

    task automatic test_overflow;
        logic [15:0] q[$];
        q = '{16'h7000, 16'h7000, 16'h7000, 16'h7000};
        do_run(q, 0, 1, 1'b0, "ovf_pos");
        q = '{16'h9000, 16'h9000, 16'h9000, 16'h9000};
        do_run(q, 0, 1, 1'b0, "ovf_neg");
        q = {};
        for (int i = 0; i < 255; i++) q.push_back(16'h8000);
        do_run(q, 0, 0, 1'b0, "max_len_neg");
        q = {};
        for (int i = 0; i < 255; i++) q.push_back(16'h7FFF);
        do_run(q, 0, 0, 1'b0, "max_len_pos");
    endtask

    task automatic test_zero_len;
        logic [15:0] q[$];
        do_run(q, 0, 2, 1'b0, "zero_len");
    endtask

    task automatic test_stall;
        logic [15:0] q[$] = '{16'h0280, 16'hFEC0};
        do_run(q, 5, 4, 1'b0, "stall");
    endtask

    task automatic test_reset_mid;
        logic [15:0] q[$] = '{16'h0040};
        bus.start = 1'b1; bus.len = 8'd5;
        step;
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 16'h1234;
            step;
        end
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_ovf, bus.busy} !== 4'b0 ||
            bus.out !== 16'h0000) begin
            errors++;
            $display("FAIL async reset: rdy=%b vld=%b ovf=%b busy=%b out=%h want 0",
                     bus.in_ready, bus.out_valid, bus.out_ovf, bus.busy, bus.out);
        end
        step;
        checks++;
        if (bus.busy !== 1'b0 || bus.out !== 16'h0000) begin
            errors++;
            $display("FAIL reset hold: busy=%b out=%h want 0 0000", bus.busy, bus.out);
        end
        rst = 1'b0;
        step;
        do_run(q, 0, 0, 1'b0, "after_reset");
    endtask

    task automatic test_start_ignored;
        logic [15:0] q[$] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
        do_run(q, 1, 2, 1'b1, "start_ignored");
    endtask

    task automatic test_random;
        logic [15:0] q[$];
        int n;
        for (int r = 0; r < 30; r++) begin
            q = {};
            n = $urandom_range(0, 20);
            for (int i = 0; i < n; i++)
                q.push_back((r % 3 == 0) ? 16'($urandom_range(16'h6000, 16'h7FFF))
                                         : 16'($urandom));
            do_run(q, $urandom_range(0, 2), $urandom_range(0, 2),
                   1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_overflow;
        test_zero_len;
        test_stall;
        test_reset_mid;
        test_start_ignored;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fix_acc.md
FIX_ACC -- requirements
Module: fix_acc

Interface
REQ-001 SHALL have parameter LEN_W, default 8: width of the term-count input; the accumulator width is 16+LEN_W.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: begins a new accumulation; sampled only in IDLE.
REQ-005 SHALL have port len, input, LEN_W: number of terms to sum; captured on start.
REQ-006 SHALL have port in_valid, input, 1: in_data holds a valid Q8.8 term (e.g. a FixMul product).
REQ-007 SHALL have port in_ready, output, 1: block accepts a term this cycle.
REQ-008 SHALL have port in_data, input, 16: signed Q8.8 term.
REQ-009 SHALL have port out_valid, output, 1: result is valid on out.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port out, output, 16: signed Q8.8 sum.
REQ-012 SHALL have port out_ovf, output, 1: the sum exceeded the Q8.8 range; valid with out_valid.
REQ-013 SHALL have port busy, output, 1: high in every state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ACC and DONE.
REQ-015 IDLE transitions: on start with len!=0, SHALL clear acc to 0, load cnt=len and go to ACC; on start with len==0, SHALL clear acc and go directly to DONE.
REQ-016 in_ready SHALL equal 1 only in ACC; a beat is accepted when in_valid && in_ready.
REQ-017 Each accepted beat SHALL perform acc <= acc + sign-extended in_data (16+LEN_W bits, signed, no internal wrap for any len) and cnt <= cnt-1.
REQ-018 A beat accepted with cnt==1 SHALL cause a transition to DONE, so out_valid rises in the cycle after the last accepted beat (latency 1).
REQ-019 While in_valid is low in ACC, acc and cnt SHALL hold; stalls of any length SHALL be tolerated.
REQ-020 In DONE, out_valid SHALL be 1 and out/out_ovf SHALL be held stable until out_ready; on out_valid && out_ready the FSM SHALL return to IDLE in the next cycle.
REQ-021 out_ovf SHALL be 1 iff acc > 32767 or acc < -32768.
REQ-022 start SHALL be ignored in ACC and DONE; start asserted in the same cycle as the DONE handshake SHALL be ignored, and a new run SHALL start only from IDLE.
REQ-023 out SHALL be driven combinationally from acc (see REQ-028/029); outside DONE, out SHALL be don't-care to consumers but deterministic.

Reset
REQ-024 On rst, regardless of clk or current state (including mid-ACC), the FSM SHALL enter IDLE, and acc and cnt SHALL become 0.
REQ-025 During and after reset: in_ready=0, out_valid=0, out_ovf=0, busy=0, out=16'h0000.
REQ-026 After rst deasserts, the first start SHALL behave exactly as after power-up; no partial sum SHALL survive.

Configuration
REQ-027 The macro FIX_ACC_SAT_EN SHALL select the output overflow policy.
REQ-028 With FIX_ACC_SAT_EN defined: out SHALL saturate to 16'h7FFF when acc > 32767, to 16'h8000 when acc < -32768, and equal acc[15:0] otherwise.
REQ-029 Without FIX_ACC_SAT_EN: out SHALL equal acc[15:0] (two's-complement wrap); out_ovf SHALL still be reported per REQ-021.

Verification
REQ-030 len=3, terms 0x0100, 0x0180, 0xFF00 (1.0, 1.5, -1.0), in_valid held high -> out_valid in the cycle after the 3rd beat, out=0x0180, out_ovf=0.
REQ-031 len=4, four terms of 0x7000 -> out_ovf=1; out=0x7FFF with FIX_ACC_SAT_EN, out=0xC000 without; repeat with 0x9000 -> 0x8000 / 0x4000.
REQ-032 len=0 with start -> DONE next cycle, out=0x0000, out_ovf=0, in_ready never asserted.
REQ-033 len=2 with in_valid gaps of 5 cycles and out_ready held low for 4 cycles in DONE -> sum correct, out stable while stalled, return to IDLE after the handshake.
REQ-034 rst pulsed after 2 of 5 beats, then start with len=1 and term 0x0040 -> out=0x0040 (no residue), and all outputs at reset values during rst.
REQ-035 start pulsed during ACC and in the DONE handshake cycle -> ignored; the result and cnt are unaffected.
